// File: rtl/alu_multdiv_seq.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes. The sign is applied when the result is written.
module alu_multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             fin;
    logic             neg;
    logic             div_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    // Shared datapath: {hi, lo} for multiply, {remainder, quotient} for divide
    logic [2*WIDTH:0] acc;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   rem_diff;
    logic [2*WIDTH:0]   div_next;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic               mul_exc, div_exc;

    // MIN maps to 2^(WIDTH-1), which still fits as an unsigned magnitude
    assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    assign mul_sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    assign mul_next = {1'b0, mul_sum, acc[WIDTH-1:1]};

    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_diff = {1'b0, rem_sh} - {2'b00, mag_b};
    assign div_next = rem_diff[WIDTH+1] ? {rem_sh, acc[WIDTH-2:0], 1'b0}
                                        : {rem_diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};

    assign prod_s  = neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    assign mul_exc = !(&prod_s[2*WIDTH-1:WIDTH-1]) && (|prod_s[2*WIDTH-1:WIDTH-1]);
    assign quot_s  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // A positive quotient with the top bit set only arises from MIN / -1
    assign div_exc = !neg && acc[WIDTH-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            fin            <= 1'b0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            mag_a          <= '0;
            mag_b          <= '0;
            acc            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            state          <= ctrl_MULT ? MULT : DIV;
            count          <= '0;
            fin            <= 1'b0;
            neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero       <= !ctrl_MULT && (data_operandB == '0);
            mag_a          <= abs_a;
            mag_b          <= abs_b;
            acc            <= {{(WIDTH+1){1'b0}}, ctrl_MULT ? abs_b : abs_a};
            data_resultRDY <= 1'b0;
            busy           <= 1'b1;
        end else begin
            case (state)
                MULT: begin
                    if (fin) begin
                        state          <= DONE;
                        data_result    <= prod_s[WIDTH-1:0];
                        data_exception <= mul_exc;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                    end else begin
                        acc <= mul_next;
                        if (count == LAST) fin <= 1'b1;
                        else               count <= count + CNT_W'(1);
                    end
                end
                DIV: begin
                    if (div_zero || fin) begin
                        state          <= DONE;
                        data_result    <= div_zero ? '0 : quot_s;
                        data_exception <= div_zero | div_exc;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                    end else begin
                        acc <= div_next;
                        if (count == LAST) fin <= 1'b1;
                        else               count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    data_resultRDY <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multdiv_seq.sv
// Directed-vector and reference-model bench for alu_multdiv_seq at WIDTH=32 and WIDTH=8.
module tb_alu_multdiv_seq;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] a32, b32, res32;
    logic        m32, d32, exc32, rdy32, busy32;
    logic [7:0]  a8, b8, res8;
    logic        m8, d8, exc8, rdy8, busy8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    alu_multdiv_seq #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clock(clock), .reset_n(reset_n),
        .data_operandA(a32), .data_operandB(b32),
        .ctrl_MULT(m32), .ctrl_DIV(d32),
        .data_result(res32), .data_exception(exc32),
        .data_resultRDY(rdy32), .busy(busy32)
    );

    alu_multdiv_seq #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clock(clock), .reset_n(reset_n),
        .data_operandA(a8), .data_operandB(b8),
        .ctrl_MULT(m8), .ctrl_DIV(d8),
        .data_result(res8), .data_exception(exc8),
        .data_resultRDY(rdy8), .busy(busy8)
    );

    typedef struct {
        bit          w8;
        bit          div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          exc;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic peek(input bit w8, output logic rdy, output logic bsy,
                        output logic exc, output logic [31:0] res);
        if (w8) begin rdy = rdy8;  bsy = busy8;  exc = exc8;  res = {24'd0, res8}; end
        else    begin rdy = rdy32; bsy = busy32; exc = exc32; res = res32;         end
    endtask

    // Pulse a start; returns at the falling edge right after the sampling edge k
    task automatic start_op(input bit w8, input bit div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        if (w8) begin a8 = a[7:0]; b8 = b[7:0]; m8 = !div; d8 = div; end
        else    begin a32 = a;     b32 = b;     m32 = !div; d32 = div; end
        @(negedge clock);
        m8 = 1'b0; d8 = 1'b0; m32 = 1'b0; d32 = 1'b0;
        a8 = 8'h5A; b8 = 8'hA5; a32 = 32'hDEAD_BEEF; b32 = 32'h0BAD_F00D;
    endtask

    // lat = number of edges after k until the strobe (0 on timeout); ok = busy high
    // and result held until the strobe, busy low at the strobe
    task automatic wait_rdy(input bit w8, input int limit, output int lat,
                            output logic [31:0] res, output logic exc, output bit ok);
        logic        r, b, e;
        logic [31:0] v, prev;
        lat = 0; res = '0; exc = 1'b0;
        peek(w8, r, b, e, prev);
        ok = b && !r;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clock);
            peek(w8, r, b, e, v);
            if (r) begin
                lat = n; res = v; exc = e; ok = ok && !b;
                break;
            end
            ok = ok && b && (v === prev);
        end
    endtask

    vec_t        vecs[$];
    int          lat, strobes;
    logic [31:0] res, eres;
    logic        exc, eexc, r, b, e;
    bit          ok;

    initial begin
        reset_n = 1'b0;
        a32 = '0; b32 = '0; m32 = 1'b0; d32 = 1'b0;
        a8  = '0; b8  = '0; m8  = 1'b0; d8  = 1'b0;

        vecs.push_back('{0, 0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 33});
        vecs.push_back('{0, 0, 32'h4000_0000, 32'd4,         32'h0000_0000, 1, 33});
        vecs.push_back('{0, 0, 32'h8000_0000, 32'd1,         32'h8000_0000, 0, 33});
        vecs.push_back('{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 33});
        vecs.push_back('{0, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 33});
        vecs.push_back('{0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 33});
        vecs.push_back('{0, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 33});
        vecs.push_back('{0, 1, 32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 33});
        vecs.push_back('{0, 1, 32'd3,         32'd7,         32'h0000_0000, 0, 33});
        vecs.push_back('{0, 1, 32'hFFFF_FFFD, 32'd7,         32'h0000_0000, 0, 33});
        vecs.push_back('{0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 33});
        vecs.push_back('{0, 1, 32'h8000_0000, 32'd1,         32'h8000_0000, 0, 33});
        vecs.push_back('{0, 1, 32'd5,         32'd0,         32'h0000_0000, 1, 1});
        vecs.push_back('{0, 1, 32'd100,       32'd7,         32'd14,        0, 33});
        vecs.push_back('{1, 0, 32'h7F,        32'h02,        32'hFE,        1, 9});
        vecs.push_back('{1, 1, 32'h80,        32'hFF,        32'h80,        1, 9});
        vecs.push_back('{1, 0, 32'h80,        32'h80,        32'h00,        1, 9});
        vecs.push_back('{1, 0, 32'hFF,        32'h80,        32'h80,        1, 9});
        vecs.push_back('{1, 1, 32'h7F,        32'hFE,        32'hC1,        0, 9});
        vecs.push_back('{1, 1, 32'h05,        32'h00,        32'h00,        1, 1});

        #12;
        chk("reset32", {res32, 29'd0, exc32, rdy32, busy32}, 64'd0);
        chk("reset8",  {res8, 5'd0, exc8, rdy8, busy8}, 64'd0);
        @(negedge clock) reset_n = 1'b1;

        foreach (vecs[i]) begin
            start_op(vecs[i].w8, vecs[i].div, vecs[i].a, vecs[i].b);
            wait_rdy(vecs[i].w8, 40, lat, res, exc, ok);
            chk($sformatf("vec%0d_result", i),  res, vecs[i].res);
            chk($sformatf("vec%0d_exc", i),     exc, vecs[i].exc);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_busy_hold", i), ok, 1'b1);
            @(negedge clock);
            peek(vecs[i].w8, r, b, e, eres);
            chk($sformatf("vec%0d_strobe_drop", i), {r, b}, 2'b00);
        end

        // Restart: multiply aborted by a divide sampled ten edges later
        start_op(0, 0, 32'd3, 32'd5);
        strobes = 0;
        repeat (8) begin @(negedge clock); if (rdy32) strobes++; end
        start_op(0, 1, 32'd100, 32'd7);
        wait_rdy(0, 60, lat, res, exc, ok);
        chk("restart_latency", lat, 33);
        chk("restart_result", res, 32'd14);
        chk("restart_exc", exc, 1'b0);
        repeat (40) begin @(negedge clock); if (rdy32) strobes++; end
        chk("restart_extra_strobes", strobes, 0);

        // Asynchronous reset mid-operation
        start_op(0, 0, 32'h1234, 32'h10);
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", {res32, 29'd0, exc32, rdy32, busy32}, 64'd0);
        @(negedge clock) reset_n = 1'b1;
        strobes = 0;
        repeat (50) begin @(negedge clock); if (rdy32 || busy32) strobes++; end
        chk("post_reset_quiet", strobes, 0);

        // WIDTH=8 against a signed integer reference model
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            bit         rdiv;
            int         sa, sb, p, elat;
            ra   = 8'($urandom);
            rb   = (i % 40 == 7) ? 8'h00 : 8'($urandom);
            rdiv = 1'($urandom);
            sa = $signed(ra);
            sb = $signed(rb);
            elat = 9;
            if (!rdiv) begin
                p = sa * sb;
                eres = 32'(p) & 32'hFF;
                eexc = (p > 127) || (p < -128);
            end else if (sb == 0) begin
                eres = 32'h0; eexc = 1'b1; elat = 1;
            end else begin
                p = sa / sb;
                eres = 32'(p) & 32'hFF;
                eexc = (p == 128);
            end
            start_op(1, rdiv, {24'd0, ra}, {24'd0, rb});
            wait_rdy(1, 20, lat, res, exc, ok);
            chk($sformatf("rnd%0d_%s_%0d_%0d_result", i, rdiv ? "div" : "mul", sa, sb), res, eres);
            chk($sformatf("rnd%0d_exc", i), exc, eexc);
            chk($sformatf("rnd%0d_latency", i), lat, elat);
            chk($sformatf("rnd%0d_busy_hold", i), ok, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_multdiv_seq.md
Name: alu_multdiv_seq

Overview:
- Parametrised iterative signed multiply/divide unit. Sits beside the combinational ALU in the execute stage.
- Takes the long-latency mul and div opcodes off the ALU critical path.
- Control pulses a start signal and waits for a one-cycle result-ready strobe; the pipeline stalls while the unit is busy.
- Generalises the ALU to arbitrary WIDTH and adds multi-cycle sequential behaviour with exception reporting.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥4 and even.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- data_operandA  input  WIDTH  multiplicand / dividend (two's complement)
- data_operandB  input  WIDTH  multiplier / divisor (two's complement)
- ctrl_MULT  input  1  single-cycle start pulse for multiply
- ctrl_DIV  input  1  single-cycle start pulse for divide
- data_result  output  WIDTH  product low word / quotient
- data_exception  output  1  multiply overflow, divide-by-zero, or MIN/-1
- data_resultRDY  output  1  one-cycle strobe: result valid
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset (reset_n low, asynchronous):
  - state goes to IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0; counter and internal registers cleared.
  - Reset asserted mid-operation aborts the operation; no resultRDY is issued.
- States: IDLE, MULT, DIV, DONE.
- Start:
  - Operands are latched at the edge that samples ctrl_MULT or ctrl_DIV high (edge k).
  - If both are high, MULT wins.
  - At edge k, busy rises and data_resultRDY is forced to 0.
- Restart: a start pulse in MULT, DIV or DONE aborts the current operation and begins the new one with the same latency. The aborted operation never produces resultRDY.
- MULT (radix-2 shift-add on magnitudes, sign applied at end):
  - WIDTH iterations, one per cycle.
  - At edge k+WIDTH+1, the state enters DONE and the outputs update:
    - data_result = low WIDTH bits of the 2·WIDTH signed product.
    - data_exception = 1 iff the full product is not representable in signed WIDTH bits, i.e. the upper WIDTH+1 bits are not all equal.
- DIV (restoring division on magnitudes):
  - Quotient truncates toward zero; the remainder is discarded.
  - Sign of the quotient = signA XOR signB; a zero quotient is never negative.
  - Normal latency is identical to MULT: outputs update at edge k+WIDTH+1.
  - Divisor = 0 (checked at edge k): skip iteration. At edge k+1: data_result=0, data_exception=1, enter DONE.
  - Dividend = MIN and divisor = -1: full latency; data_result=MIN, data_exception=1.
- DONE:
  - data_resultRDY=1 and busy=0 for exactly this one cycle.
  - Then return to IDLE unless a new start is sampled.
- Output hold: data_result and data_exception are registered and hold their value until the next completion. They do not change during a later operation's iterations.
- Operand inputs are ignored after edge k; changing them mid-operation has no effect.
- Counter counts 0..WIDTH-1 with no wrap. It is cleared on every start.

Test Plan:
- WIDTH=32: A=7, B=-3, MULT pulse at edge k -> resultRDY high only at edge k+33; result=0xFFFFFFEB (-21), exception=0; busy high edges k..k+32.
- A=0x40000000, B=4, MULT -> result=0x00000000, exception=1. Also A=0x80000000, B=1 -> result=0x80000000, exception=0.
- DIV cases:
  - -7/2 -> 0xFFFFFFFD (-3), exception=0.
  - 7/-7 -> 0xFFFFFFFF.
  - 3/7 -> 0.
  - 0x80000000/0xFFFFFFFF -> 0x80000000, exception=1.
- DIV 5/0 at edge k -> resultRDY at edge k+1; result=0, exception=1. Previous result holds until then.
- Restart and reset:
  - MULT 3×5 started; at k+10, DIV 100/7 pulsed -> single resultRDY at k+10+33 with result=14. No strobe for the aborted multiply.
  - reset_n pulsed low mid-operation -> all outputs 0 immediately (asynchronously); no strobe afterwards.
- Parameter sweep WIDTH=8: 0x7F × 2 -> exception=1, result=0xFE; -128/-1 -> exception=1. Latency is 9 cycles. Compare random operands against a reference model for 1000 operations.
